// File: rtl/dm_sync.sv
// Single-port 32-bit data memory with byte/half/word access, alignment checking
// and a post-reset zero-fill sweep that holds off requests until it completes.
`timescale 1ns/1ps
module dm_sync #(
  parameter int AW             = 10,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_req,
  input  logic          i_we,
  input  logic [AW+1:0] i_addr,
  input  logic [1:0]    i_size,
  input  logic          i_uext,
  input  logic [31:0]   i_wdata,
  output logic          o_ready,
  output logic          o_rvalid,
  output logic [31:0]   o_rdata,
  output logic          o_misalign,
  output logic          o_dbg_state
);

  localparam int DEPTH = 2**AW;

  // Handshake: a request is taken on a rising edge with i_req=1 and o_ready=1;
  // its response is a one-cycle o_rvalid pulse on the following cycle.

  typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_cnt, w_cnt_nxt;

  logic [3:0][7:0] r_ram [DEPTH];

  logic [AW-1:0]   w_idx;
  logic [1:0]      w_off;
  logic            w_accept;
  logic            w_mis;
  logic [3:0]      w_be;
  logic [31:0]     w_wlanes;
  logic            w_clr_we;
  logic            w_st_we;
  logic [3:0][7:0] w_word;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [31:0]     w_load;

  assign o_ready     = (r_state == S_RUN);
  assign o_dbg_state = r_state;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (r_state == S_CLEAR) begin
      w_cnt_nxt = r_cnt + AW'(1);
      if (!CLEAR_ON_RESET || (r_cnt == AW'(DEPTH - 1))) begin
        w_state_nxt = S_RUN;
      end
    end
  end

  assign w_idx    = i_addr[AW+1:2];
  assign w_off    = i_addr[1:0];
  assign w_accept = i_req && o_ready;

  always_comb begin
    w_mis    = 1'b0;
    w_be     = 4'b0000;
    w_wlanes = i_wdata;
    case (i_size)
      2'b00: begin
        w_be     = 4'b0001 << w_off;
        w_wlanes = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        w_mis    = w_off[0];
        w_be     = w_off[1] ? 4'b1100 : 4'b0011;
        w_wlanes = {2{i_wdata[15:0]}};
      end
      2'b10: begin
        w_mis = (w_off != 2'b00);
        w_be  = 4'b1111;
      end
      default: w_mis = 1'b1;
    endcase
  end

  // Gated by i_rst_n so the sweep never touches memory while reset is held.
  assign w_clr_we = i_rst_n && CLEAR_ON_RESET && (r_state == S_CLEAR);
  assign w_st_we  = i_rst_n && w_accept && i_we && !w_mis;

  always_ff @(posedge i_clk) begin
    if (w_clr_we) begin
      r_ram[r_cnt] <= '0;
    end else if (w_st_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_ram[w_idx][i] <= w_wlanes[i*8 +: 8];
      end
    end
  end

  assign w_word = r_ram[w_idx];
  assign w_byte = w_word[w_off];
  assign w_half = w_off[1] ? {w_word[3], w_word[2]} : {w_word[1], w_word[0]};

  always_comb begin
    case (i_size)
      2'b00:   w_load = i_uext ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_load = i_uext ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load = w_word;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rvalid   <= 1'b0;
      o_rdata    <= '0;
      o_misalign <= 1'b0;
    end else begin
      o_rvalid <= w_accept;
      if (w_accept) begin
        o_misalign <= w_mis;
        o_rdata    <= (i_we || w_mis) ? 32'd0 : w_load;
      end
    end
  end

endmodule

// File: tb/tb_dm_sync.sv
// Directed and model-checked bench for dm_sync (AW=10, CLEAR_ON_RESET=1).
`timescale 1ns/1ps
module tb_dm_sync;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [11:0] addr = '0;
  logic [1:0]  size = '0;
  logic        uext = 1'b0;
  logic [31:0] wdata = '0;
  logic        ready, rvalid, misalign, dbg_state;
  logic [31:0] rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dm_sync #(.AW(10), .CLEAR_ON_RESET(1'b1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_we(we), .i_addr(addr),
    .i_size(size), .i_uext(uext), .i_wdata(wdata), .o_ready(ready),
    .o_rvalid(rvalid), .o_rdata(rdata), .o_misalign(misalign),
    .o_dbg_state(dbg_state)
  );

  // Drivers: called at posedge+1, return at the next posedge+1.
  task automatic do_req(input logic w, input logic [11:0] a, input logic [1:0] s,
                        input logic u, input logic [31:0] d);
    req = 1'b1; we = w; addr = a; size = s; uext = u; wdata = d;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    req = 1'b0; we = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_ready(output int n, output int seen_rvalid);
    n = 0; seen_rvalid = 0;
    while (ready !== 1'b1 && n < 2000) begin
      @(posedge clk); #1;
      n++;
      if (rvalid !== 1'b0) seen_rvalid++;
    end
  endtask

  task automatic test_reset();
    int n, sv;
    #1;
    checks++;
    if ({ready, rvalid, misalign, dbg_state, rdata} !== 36'd0) begin
      errors++;
      $display("FAIL reset_outputs ready=%b rvalid=%b misalign=%b state=%b rdata=%h required all 0",
               ready, rvalid, misalign, dbg_state, rdata);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold_ready got=%b required=0", ready);
    end
    rst_n = 1'b1;
    wait_ready(n, sv);
    checks++;
    if (n != 1024 || sv != 0) begin
      errors++;
      $display("FAIL clear_length cycles=%0d rvalids=%0d required 1024 and 0", n, sv);
    end
  endtask

  task automatic test_clear_load();
    logic [11:0] ta [3] = '{12'hFFC, 12'h004, 12'h010};
    for (int i = 0; i < 3; i++) begin
      do_req(1'b0, ta[i], 2'b10, 1'b0, 32'd0);
      checks++;
      if (rvalid !== 1'b1 || rdata !== 32'd0 || misalign !== 1'b0) begin
        errors++;
        $display("FAIL clear_load@%h rvalid=%b rdata=%h mis=%b required 1/00000000/0",
                 ta[i], rvalid, rdata, misalign);
      end
    end
  endtask

  task automatic test_ext();
    logic        tw [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [11:0] ta [6] = '{12'h010, 12'h013, 12'h013, 12'h012, 12'h010, 12'h010};
    logic [1:0]  ts [6] = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00};
    logic        tu [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] te [6] = '{32'h0, 32'hFFFFFFA1, 32'h000000A1, 32'hFFFFA1B2,
                            32'h0000C3D4, 32'hFFFFFFD4};
    for (int i = 0; i < 6; i++) begin
      do_req(tw[i], ta[i], ts[i], tu[i], 32'hA1B2C3D4);
      checks++;
      if (rvalid !== 1'b1 || rdata !== te[i] || misalign !== 1'b0) begin
        errors++;
        $display("FAIL ext_%0d rvalid=%b rdata=%h mis=%b required 1/%h/0",
                 i, rvalid, rdata, misalign, te[i]);
      end
    end
    idle();
    checks++;
    if (rvalid !== 1'b0 || rdata !== 32'hFFFFFFD4) begin
      errors++;
      $display("FAIL ext_idle rvalid=%b rdata=%h required 0/ffffffd4", rvalid, rdata);
    end
  endtask

  task automatic test_raw();
    do_req(1'b1, 12'h012, 2'b01, 1'b0, 32'h00005566);
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'd0 || misalign !== 1'b0) begin
      errors++;
      $display("FAIL raw_store rvalid=%b rdata=%h mis=%b required 1/00000000/0", rvalid, rdata, misalign);
    end
    do_req(1'b0, 12'h010, 2'b10, 1'b0, 32'd0);
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h5566C3D4 || misalign !== 1'b0) begin
      errors++;
      $display("FAIL raw_load rvalid=%b rdata=%h mis=%b required 1/5566c3d4/0", rvalid, rdata, misalign);
    end
    idle();
    checks++;
    if (rvalid !== 1'b0 || rdata !== 32'h5566C3D4 || misalign !== 1'b0) begin
      errors++;
      $display("FAIL raw_hold rvalid=%b rdata=%h mis=%b required 0/5566c3d4/0", rvalid, rdata, misalign);
    end
  endtask

  task automatic test_misalign();
    logic        tw [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [11:0] ta [9] = '{12'h020, 12'h021, 12'h020, 12'h001, 12'h020,
                            12'h023, 12'h023, 12'h020, 12'h022};
    logic [1:0]  ts [9] = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b11,
                            2'b01, 2'b00, 2'b10, 2'b11};
    logic [31:0] td [9] = '{32'h12345678, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0,
                            32'h0000BEEF, 32'h0000009A, 32'h0, 32'hFFFFFFFF};
    logic [31:0] te [9] = '{32'h0, 32'h0, 32'h12345678, 32'h0, 32'h0,
                            32'h0, 32'h0, 32'h9A345678, 32'h0};
    logic        tm [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 9; i++) begin
      do_req(tw[i], ta[i], ts[i], 1'b0, td[i]);
      checks++;
      if (rvalid !== 1'b1 || rdata !== te[i] || misalign !== tm[i]) begin
        errors++;
        $display("FAIL mis_%0d rvalid=%b rdata=%h mis=%b required 1/%h/%b",
                 i, rvalid, rdata, misalign, te[i], tm[i]);
      end
    end
    do_req(1'b0, 12'h020, 2'b10, 1'b0, 32'h0);
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h9A345678 || misalign !== 1'b0) begin
      errors++;
      $display("FAIL mis_unchanged rdata=%h mis=%b required 9a345678/0", rdata, misalign);
    end
    do_req(1'b0, 12'h006, 2'b10, 1'b0, 32'h0);
    idle();
    checks++;
    if (rvalid !== 1'b0 || misalign !== 1'b1 || rdata !== 32'd0) begin
      errors++;
      $display("FAIL mis_hold rvalid=%b mis=%b rdata=%h required 0/1/00000000", rvalid, misalign, rdata);
    end
  endtask

  task automatic test_reset_mid();
    int n, sv;
    req = 1'b1; we = 1'b0; addr = 12'h020; size = 2'b10; uext = 1'b0;
    @(posedge clk);
    req = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (rvalid !== 1'b0 || ready !== 1'b0 || rdata !== 32'd0 || dbg_state !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async rvalid=%b ready=%b rdata=%h state=%b required 0/0/0/0",
               rvalid, ready, rdata, dbg_state);
    end
    sv = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (rvalid !== 1'b0 || ready !== 1'b0) sv++;
    end
    checks++;
    if (sv != 0) begin
      errors++;
      $display("FAIL midreset_hold bad_cycles=%0d required 0", sv);
    end
    rst_n = 1'b1;
    wait_ready(n, sv);
    checks++;
    if (n != 1024 || sv != 0) begin
      errors++;
      $display("FAIL midreset_reclear cycles=%0d rvalids=%0d required 1024 and 0", n, sv);
    end
    do_req(1'b0, 12'h020, 2'b10, 1'b0, 32'd0);
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'd0 || misalign !== 1'b0) begin
      errors++;
      $display("FAIL midreset_wiped rvalid=%b rdata=%h mis=%b required 1/00000000/0", rvalid, rdata, misalign);
    end
  endtask

  task automatic test_random();
    logic [7:0]  mdl [64];
    logic [31:0] exp_d, d;
    logic [15:0] h;
    logic        exp_m, w, u;
    logic [1:0]  s;
    int          a, bad, resp;
    for (int i = 0; i < 64; i++) mdl[i] = 8'h00;
    bad = 0; resp = 0;
    for (int k = 0; k < 100; k++) begin
      w = 1'($urandom_range(0, 1));
      u = 1'($urandom_range(0, 1));
      s = 2'($urandom_range(0, 3));
      a = $urandom_range(0, 63);
      d = $urandom;
      exp_m = (s == 2'b11) || (s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 2'b00);
      exp_d = 32'd0;
      if (!exp_m) begin
        if (w) begin
          mdl[a] = d[7:0];
          if (s != 2'b00) mdl[a+1] = d[15:8];
          if (s == 2'b10) begin
            mdl[a+2] = d[23:16];
            mdl[a+3] = d[31:24];
          end
        end else if (s == 2'b00) begin
          exp_d = u ? {24'd0, mdl[a]} : {{24{mdl[a][7]}}, mdl[a]};
        end else if (s == 2'b01) begin
          h = {mdl[a+1], mdl[a]};
          exp_d = u ? {16'd0, h} : {{16{h[15]}}, h};
        end else begin
          exp_d = {mdl[a+3], mdl[a+2], mdl[a+1], mdl[a]};
        end
      end
      do_req(w, 12'(a), s, u, d);
      if (rvalid === 1'b1) resp++;
      checks++;
      if (rvalid !== 1'b1 || rdata !== exp_d || misalign !== exp_m) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL rand_%0d we=%b a=%h sz=%b u=%b rvalid=%b rdata=%h mis=%b required 1/%h/%b",
                   k, w, a, s, u, rvalid, rdata, misalign, exp_d, exp_m);
      end
    end
    idle();
    checks++;
    if (resp != 100 || rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rand_resp_count responses=%0d trailing_rvalid=%b required 100/0", resp, rvalid);
    end
  endtask

  initial begin
    test_reset();
    test_clear_load();
    test_ext();
    test_raw();
    test_misalign();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dm_sync.md
DM_SYNC -- requirements
Module: dm_sync

Interface
REQ-001 Parameter AW, default 10, word-address width; the memory SHALL hold DEPTH = 2**AW 32-bit words.
REQ-002 Parameter CLEAR_ON_RESET, default 1; when 1, the memory SHALL be zero-filled after reset.
REQ-003 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 req  in  1  request strobe, sampled only when ready=1.
REQ-006 we  in  1  1 = store, 0 = load.
REQ-007 addr  in  AW+2  byte address; addr[AW+1:2] is the word index and addr[1:0] is the byte offset.
REQ-008 size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-009 uext  in  1  load extension: 1 = zero-extend, 0 = sign-extend.
REQ-010 wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 ready  out  1  block accepts a request this cycle.
REQ-012 rvalid  out  1  one-cycle response pulse for each accepted request.
REQ-013 rdata  out  32  load result, valid when rvalid=1.
REQ-014 misalign  out  1  error flag for the response, valid when rvalid=1.

Function
REQ-015 The FSM SHALL have two states, CLEAR and RUN; ready SHALL be 1 only in RUN.
REQ-016 CLEAR: a word counter SHALL start at 0 and write 0 to ram[cnt] each cycle; after cnt = DEPTH-1 the FSM SHALL enter RUN, so ready rises exactly DEPTH cycles after rst_n deasserts.
REQ-017 With CLEAR_ON_RESET=0, the FSM SHALL enter RUN on the first clock edge after rst_n deasserts, and memory contents are undefined.
REQ-018 Accept: a request is accepted on a rising edge where req=1 and ready=1; the block SHALL accept at most one request per cycle and SHALL sustain back-to-back acceptance.
REQ-019 Alignment: a request is misaligned if size=11, or size=01 with addr[0]=1, or size=10 with addr[1:0]!=00.
REQ-020 Store byte enables: byte -> lane addr[1:0]; half -> lanes {addr[1],0} and {addr[1],1}; word -> all four lanes.
REQ-021 Store data: the byte or half SHALL be replicated across the lanes; only enabled lanes are written, at the accept edge; unenabled lanes SHALL be unchanged.
REQ-022 A misaligned store SHALL NOT modify memory.
REQ-023 Load: the word SHALL be read at the accept edge, and rdata SHALL appear with rvalid on the following cycle (latency 1).
REQ-024 Load lane selection: byte lane = addr[1:0]; half lane = addr[1]; the result is extended to 32 bits per uext (word ignores uext).
REQ-025 Response: every accepted request SHALL produce rvalid=1 for exactly one cycle, one cycle after acceptance.
REQ-026 Response values: misalign = alignment result; rdata = 0 for stores and for misaligned loads.
REQ-027 Read-after-write: a load accepted the cycle after a store to the same word SHALL return the newly written data.
REQ-028 When no request is accepted, rvalid SHALL be 0, and rdata and misalign SHALL hold their last values.

Reset
REQ-029 rst_n=0 SHALL immediately force state=CLEAR, cnt=0, ready=0, rvalid=0, rdata=0, misalign=0.
REQ-030 rst_n asserted mid-operation SHALL drop any pending response (no rvalid); after release, CLEAR SHALL restart from word 0.
REQ-031 Memory SHALL NOT be written while rst_n=0.

Verification
REQ-032 Release reset (AW=10, CLEAR_ON_RESET=1) -> ready=0 for 1024 cycles then 1; a word load from any address -> rdata=0x00000000, misalign=0.
REQ-033 Store word 0xA1B2C3D4 @0x10; load byte @0x13 with uext=0 -> 0xFFFFFFA1; with uext=1 -> 0x000000A1; load half @0x12 with uext=0 -> 0xFFFFA1B2.
REQ-034 Store half 0x5566 @0x12 over the previous word; load word @0x10 on the next cycle -> 0x5566C3D4 (back-to-back read-after-write).
REQ-035 Store word 0xFFFFFFFF @0x21 -> rvalid with misalign=1; load word @0x20 -> the prior contents, unchanged; load half @0x01 -> misalign=1, rdata=0.
REQ-036 Accept a load, assert rst_n=0 on the next cycle -> no rvalid pulse; ready stays 0 until CLEAR completes again.
REQ-037 Issue 100 random back-to-back requests compared against a byte-array model -> every rvalid, rdata and misalign value matches, with exactly one response per accepted request.
